// File: rtl/clock_disp.sv
// Multiplexed 4-digit mm:ss 7-segment driver with per-frame digit snapshot and carry LED stretch.
// Define CLOCK_DISP_BLINK_EN to blink the colon with the seconds LSB instead of holding it lit.
module clock_disp #(
   parameter int unsigned SCAN_DIV = 16,
   parameter int unsigned STRETCH  = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] sec1,
   input  logic [2:0] sec10,
   input  logic [3:0] min1,
   input  logic [2:0] min10,
   input  logic       CA,
   input  logic       blank_en,
   output logic [6:0] SEG,
   output logic [3:0] DIG,
   output logic       DP,
   output logic       LEDR
);

   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned CW = $clog2(STRETCH + 1);
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CMAX = CW'(STRETCH);

   logic [PW-1:0] p_q, p_d;
   logic [1:0]    s_q, s_d;
   logic [3:0]    sh_sec1, sh_min1;
   logic [2:0]    sh_sec10, sh_min10;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    seg_d;
   logic [3:0]    dig_d;
   logic          dp_d, ledr_d;
   logic          snap, dark, colon, dbad;
   logic [3:0]    dval;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_comb begin
      p_d  = (p_q == PMAX) ? '0 : p_q + 1'b1;
      s_d  = (p_q == PMAX) ? s_q + 2'd1 : s_q;
      snap = (s_q == 2'd3) && (p_q == PMAX);
   end

   // Tens digits only count to 5, so their valid range is narrower than the units digits.
   always_comb begin
      dval = '0;
      dbad = 1'b0;
      unique case (s_q)
         2'd0: begin dval = sh_sec1;          dbad = sh_sec1 > 4'd9;  end
         2'd1: begin dval = {1'b0, sh_sec10}; dbad = sh_sec10 > 3'd5; end
         2'd2: begin dval = sh_min1;          dbad = sh_min1 > 4'd9;  end
         2'd3: begin dval = {1'b0, sh_min10}; dbad = sh_min10 > 3'd5; end
      endcase
   end

   always_comb begin
      dark  = (p_q == '0) || (blank_en && (s_q == 2'd3) && (sh_min10 == 3'd0));
      colon = (s_q == 2'd2) && (p_q != '0);
      seg_d = 7'h7F;
      dig_d = 4'hF;
      if (!dark) begin
         seg_d = dbad ? 7'h3F : decode(dval);
         dig_d = ~(4'b0001 << s_q);
      end
`ifdef CLOCK_DISP_BLINK_EN
      dp_d = colon ? sh_sec1[0] : 1'b1;
`else
      dp_d = ~colon;
`endif
   end

   always_comb begin
      cnt_d = cnt_q;
      if (CA) begin
         cnt_d = CMAX;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      ledr_d = (cnt_d != '0);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         p_q      <= '0;
         s_q      <= '0;
         sh_sec1  <= '0;
         sh_sec10 <= '0;
         sh_min1  <= '0;
         sh_min10 <= '0;
         cnt_q    <= '0;
         SEG      <= 7'h7F;
         DIG      <= 4'hF;
         DP       <= 1'b1;
         LEDR     <= 1'b0;
      end else begin
         p_q   <= p_d;
         s_q   <= s_d;
         cnt_q <= cnt_d;
         SEG   <= seg_d;
         DIG   <= dig_d;
         DP    <= dp_d;
         LEDR  <= ledr_d;
         if (snap) begin
            sh_sec1  <= sec1;
            sh_sec10 <= sec10;
            sh_min1  <= min1;
            sh_min10 <= min10;
         end
      end
   end

endmodule

// File: tb/tb_clock_disp.sv
// Self-checking bench for clock_disp: vector table, hand-written corner sequences and random
// stimulus compared against a cycle-count based reference model.
module tb_clock_disp;

   localparam int SD = 4;
   localparam int ST = 8;
   localparam int FR = 4 * SD;
`ifdef CLOCK_DISP_BLINK_EN
   localparam bit Blink = 1'b1;
`else
   localparam bit Blink = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] sec1 = '0;
   logic [2:0] sec10 = '0;
   logic [3:0] min1 = '0;
   logic [2:0] min10 = '0;
   logic       CA = 1'b0;
   logic       blank_en = 1'b0;
   logic [6:0] SEG;
   logic [3:0] DIG;
   logic       DP;
   logic       LEDR;

   clock_disp #(.SCAN_DIV(SD), .STRETCH(ST)) dut (
      .CLK(CLK), .RST(RST), .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
      .CA(CA), .blank_en(blank_en), .SEG(SEG), .DIG(DIG), .DP(DP), .LEDR(LEDR)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;

   // Model: t counts clock edges since reset release; scan position is pure arithmetic on t.
   int t = 0;
   int last_ca = -1000;
   int sh[4] = '{0, 0, 0, 0};
   logic [6:0] segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      logic [3:0]      s1;
      logic [2:0]      s10;
      logic [3:0]      m1;
      logic [2:0]      m10;
      logic            blank;
      logic [3:0][6:0] seg;   // {slot3, slot2, slot1, slot0}
      logic [3:0][3:0] dig;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0d time=%0t", nm, got, exp, t, $time);
      end
   endtask

   task automatic model_reset();
      t = 0;
      last_ca = -1000;
      for (int i = 0; i < 4; i++) sh[i] = 0;
   endtask

   task automatic tick();
      int p, s, d;
      bit oor;
      logic [6:0] es;
      logic [3:0] ed;
      logic edp, eled;
      p = t % SD;
      s = (t / SD) % 4;
      d = sh[s];
      oor = (s % 2 == 0) ? (d > 9) : (d > 5);
      if (p == 0 || (blank_en && s == 3 && sh[3] == 0)) begin
         es = 7'h7F;
         ed = 4'hF;
      end else begin
         es = oor ? 7'h3F : segtab[d];
         ed = 4'hF ^ (4'd1 << s);
      end
      edp = (s == 2 && p != 0) ? (Blink ? sh[0][0] : 1'b0) : 1'b1;
      if (CA) last_ca = t;
      eled = (t - last_ca) < ST;
      if (s == 3 && p == SD - 1) begin
         sh[0] = int'(sec1);
         sh[1] = int'(sec10);
         sh[2] = int'(min1);
         sh[3] = int'(min10);
      end
      t++;
      @(posedge CLK);
      #1;
      chk("model_seg", {1'b0, SEG}, {1'b0, es});
      chk("model_dig", {4'b0, DIG}, {4'b0, ed});
      chk("model_dp", {7'b0, DP}, {7'b0, edp});
      chk("model_ledr", {7'b0, LEDR}, {7'b0, eled});
   endtask

   // Advance until the outputs reflect scan position (s,p).
   task automatic show(input int s, input int p);
      int tgt;
      tgt = (s * SD + p + 1) % FR;
      do tick(); while (t % FR != tgt);
   endtask

   task automatic set_time(input logic [2:0] m10, input logic [3:0] m1,
                           input logic [2:0] s10, input logic [3:0] s1);
      min10 = m10;
      min1  = m1;
      sec10 = s10;
      sec1  = s1;
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_seg"}, {1'b0, SEG}, 8'h7F);
      chk({nm, "_dig"}, {4'b0, DIG}, 8'h0F);
      chk({nm, "_dp"}, {7'b0, DP}, 8'h01);
      chk({nm, "_ledr"}, {7'b0, LEDR}, 8'h00);
   endtask

   initial begin
      vecs[0] = '{4'd4, 3'd3, 4'd2, 3'd1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19},
                  {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[1] = '{4'd7, 3'd0, 4'd6, 3'd5, 1'b0, {7'h12, 7'h02, 7'h40, 7'h78},
                  {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[2] = '{4'd9, 3'd5, 4'd9, 3'd0, 1'b0, {7'h40, 7'h10, 7'h12, 7'h10},
                  {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[3] = '{4'd9, 3'd5, 4'd9, 3'd0, 1'b1, {7'h7F, 7'h10, 7'h12, 7'h10},
                  {4'hF, 4'hB, 4'hD, 4'hE}};
      vecs[4] = '{4'd12, 3'd6, 4'd15, 3'd7, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F},
                  {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[5] = '{4'd3, 3'd3, 4'd2, 3'd1, 1'b1, {7'h79, 7'h24, 7'h30, 7'h30},
                  {4'h7, 4'hB, 4'hD, 4'hE}};
      vecs[6] = '{4'd6, 3'd1, 4'd8, 3'd0, 1'b0, {7'h40, 7'h00, 7'h79, 7'h02},
                  {4'h7, 4'hB, 4'hD, 4'hE}};

      // Power-on reset; inputs nonzero so the cleared shadow is visible afterwards.
      #3 RST = 1'b0;
      #1 check_reset_outputs("por");
      set_time(3'd1, 4'd2, 3'd3, 4'd4);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      model_reset();
      tick();
      chk("first_dark_dig", {4'b0, DIG}, 8'h0F);
      tick();
      chk("first_lit_seg", {1'b0, SEG}, 8'h40);
      chk("first_lit_dig", {4'b0, DIG}, 8'h0E);

      // Static patterns, one full frame each after the snapshot picks them up.
      foreach (vecs[i]) begin
         set_time(vecs[i].m10, vecs[i].m1, vecs[i].s10, vecs[i].s1);
         blank_en = vecs[i].blank;
         show(3, SD - 1);
         for (int k = 0; k < 4; k++) begin
            show(k, 0);
            chk("vec_dark_dig", {4'b0, DIG}, 8'h0F);
            show(k, 1);
            chk("vec_seg", {1'b0, SEG}, {1'b0, vecs[i].seg[k]});
            chk("vec_dig", {4'b0, DIG}, {4'b0, vecs[i].dig[k]});
            if (k == 2) chk("vec_dp", {7'b0, DP}, {7'b0, Blink ? vecs[i].s1[0] : 1'b0});
         end
      end

      // Inputs change mid-frame: remainder of the frame keeps the old snapshot.
      blank_en = 1'b0;
      set_time(3'd1, 4'd2, 3'd3, 4'd4);
      show(3, SD - 1);
      show(1, 0);
      set_time(3'd5, 4'd6, 3'd0, 4'd7);
      show(1, 2);
      chk("tear_s1", {1'b0, SEG}, 8'h30);
      show(2, 1);
      chk("tear_s2", {1'b0, SEG}, 8'h24);
      show(3, 1);
      chk("tear_s3", {1'b0, SEG}, 8'h79);
      show(0, 1);
      chk("tear_next_s0", {1'b0, SEG}, 8'h78);
      show(1, 1);
      chk("tear_next_s1", {1'b0, SEG}, 8'h40);

      // Stretcher: pulses at relative cycles 0 and 5.
      CA = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 16; i++) begin
         CA = (i == 0 || i == 5);
         tick();
         chk("stretch", {7'b0, LEDR}, {7'b0, (i <= 12)});
      end
      CA = 1'b0;
      repeat (3) tick();

      // Asynchronous reset mid-scan with the stretcher active.
      show(2, 1);
      CA = 1'b1;
      tick();
      CA = 1'b0;
      tick();
      RST = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(posedge CLK);
      #1 check_reset_outputs("held_rst");
      #3 RST = 1'b1;
      model_reset();
      tick();
      tick();
      chk("rst_restart_seg", {1'b0, SEG}, 8'h40);
      chk("rst_restart_dig", {4'b0, DIG}, 8'h0E);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            set_time(3'($urandom_range(0, 7)), 4'($urandom_range(0, 11)),
                     3'($urandom_range(0, 6)), 4'($urandom_range(0, 11)));
            if ($urandom_range(0, 3) == 0) min10 = 3'd0;
         end
         if ($urandom_range(0, 2) == 0) CA = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 40) == 0) blank_en = ~blank_en;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
